// File: rtl/axi_lite_reg_bridge.sv
// AXI4-Lite slave to simple register-bus bridge.
// One transaction in flight at a time; AW and W are accepted together.
// Read/write ties are resolved by alternating grants.
module axi_lite_reg_bridge #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  // AXI4-Lite write channels
  input  logic [ADDR_WIDTH-1:0]   s_axi_awaddr,
  input  logic                    s_axi_awvalid,
  output logic                    s_axi_awready,
  input  logic [DATA_WIDTH-1:0]   s_axi_wdata,
  input  logic [DATA_WIDTH/8-1:0] s_axi_wstrb,
  input  logic                    s_axi_wvalid,
  output logic                    s_axi_wready,
  output logic [1:0]              s_axi_bresp,
  output logic                    s_axi_bvalid,
  input  logic                    s_axi_bready,
  // AXI4-Lite read channels
  input  logic [ADDR_WIDTH-1:0]   s_axi_araddr,
  input  logic                    s_axi_arvalid,
  output logic                    s_axi_arready,
  output logic [DATA_WIDTH-1:0]   s_axi_rdata,
  output logic [1:0]              s_axi_rresp,
  output logic                    s_axi_rvalid,
  input  logic                    s_axi_rready,
  // Register bus initiator
  output logic [ADDR_WIDTH-1:0]   reg_addr,
  output logic                    reg_write_en,
  output logic [DATA_WIDTH-1:0]   reg_write_data,
  input  logic [DATA_WIDTH-1:0]   reg_read_data
);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] W_EXEC = 3'd1;
  localparam logic [2:0] W_RESP = 3'd2;
  localparam logic [2:0] R_CAPT = 3'd3;
  localparam logic [2:0] R_RESP = 3'd4;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  logic [2:0]            state_q, state_d;
  logic                  last_wr_q, last_wr_d;   // 1: last grant was a write
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                  wfull_q, wfull_d;       // captured write had all strobes set
  logic [1:0]            bresp_q, bresp_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;

  logic wr_pending;
  logic rd_pending;
  logic grant_wr;
  logic grant_rd;

  // Sub-word address bits carry no meaning on a word-wide register bus.
  logic unused_addr_lsbs;
  assign unused_addr_lsbs = ^{s_axi_awaddr[1:0], s_axi_araddr[1:0]};

  // Request detection and alternating-priority arbitration in IDLE.
  always_comb begin
    wr_pending = (state_q == IDLE) && s_axi_awvalid && s_axi_wvalid;
    rd_pending = (state_q == IDLE) && s_axi_arvalid;
    grant_wr   = wr_pending && (!rd_pending || !last_wr_q);
    grant_rd   = rd_pending && !grant_wr;
  end

  assign s_axi_awready  = grant_wr;
  assign s_axi_wready   = grant_wr;
  assign s_axi_arready  = grant_rd;

  assign s_axi_bvalid   = (state_q == W_RESP);
  assign s_axi_bresp    = bresp_q;
  assign s_axi_rvalid   = (state_q == R_RESP);
  assign s_axi_rdata    = rdata_q;
  assign s_axi_rresp    = RESP_OKAY;

  assign reg_addr       = addr_q;
  assign reg_write_data = wdata_q;
  // Derived from state so an asynchronous reset kills the strobe at once.
  assign reg_write_en   = (state_q == W_EXEC) && wfull_q;

  // Next-state and datapath capture logic for the transaction FSM.
  always_comb begin
    state_d   = state_q;
    last_wr_d = last_wr_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    wfull_d   = wfull_q;
    bresp_d   = bresp_q;
    rdata_d   = rdata_q;
    case (state_q)
      IDLE: begin
        if (grant_wr) begin
          addr_d    = {s_axi_awaddr[ADDR_WIDTH-1:2], 2'b00};
          wdata_d   = s_axi_wdata;
          wfull_d   = &s_axi_wstrb;
          last_wr_d = 1'b1;
          state_d   = W_EXEC;
        end else if (grant_rd) begin
          addr_d    = {s_axi_araddr[ADDR_WIDTH-1:2], 2'b00};
          last_wr_d = 1'b0;
          state_d   = R_CAPT;
        end
      end
      W_EXEC: begin
        // Partial writes are refused on the register bus and flagged.
        bresp_d = wfull_q ? RESP_OKAY : RESP_SLVERR;
        state_d = W_RESP;
      end
      W_RESP: begin
        if (s_axi_bready) begin
          state_d = IDLE;
        end
      end
      R_CAPT: begin
        rdata_d = reg_read_data;
        state_d = R_RESP;
      end
      R_RESP: begin
        if (s_axi_rready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset returns to IDLE with read as last grant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      last_wr_q <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      wfull_q   <= 1'b0;
      bresp_q   <= RESP_OKAY;
      rdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      last_wr_q <= last_wr_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      wfull_q   <= wfull_d;
      bresp_q   <= bresp_d;
      rdata_q   <= rdata_d;
    end
  end

endmodule
